// File: rtl/ahb_input_stage_hold_pkg.sv
// Shared AHB encodings for the bus-matrix input stage.
// Transfer type and response codes used by the master-facing port.
package ahb_input_stage_hold_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_input_stage_hold.sv
// Bus-matrix input stage: decodes a master's address phase and holds
// it while the target output stage is busy, stalling the master.
module ahb_input_stage_hold
    import ahb_input_stage_hold_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int MID_W  = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic [MID_W-1:0]  HMASTERS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic              HRESPS,
    output logic              sel_ip,
    output logic [ADDR_W-1:0] addr_ip,
    output logic [1:0]        trans_ip,
    output logic              write_ip,
    output logic [2:0]        size_ip,
    output logic [2:0]        burst_ip,
    output logic [3:0]        prot_ip,
    output logic [MID_W-1:0]  master_ip,
    output logic              mastlock_ip,
    output logic              held_tran_ip,
    input  logic              active_ip,
    input  logic              readyout_ip,
    input  logic              resp_ip
);

    logic              pend;
    logic              dphase;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [2:0]        burst_q;
    logic [3:0]        prot_q;
    logic [MID_W-1:0]  master_q;
    logic              mastlock_q;

    logic new_tran;
    logic done;
    logic load;

    assign new_tran     = HSELS & HTRANSS[1] & HREADYS;
    assign held_tran_ip = pend | new_tran;
    assign done         = held_tran_ip & active_ip & readyout_ip;
    // Master is stalled while pending, so one holding slot is enough.
    assign load         = new_tran & ~done & ~pend;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend       <= 1'b0;
            dphase     <= 1'b0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= '0;
            burst_q    <= '0;
            prot_q     <= '0;
            master_q   <= '0;
            mastlock_q <= 1'b0;
        end else begin
            if (load) begin
                addr_q     <= HADDRS;
                write_q    <= HWRITES;
                size_q     <= HSIZES;
                burst_q    <= HBURSTS;
                prot_q     <= HPROTS;
                master_q   <= HMASTERS;
                mastlock_q <= HMASTLOCKS;
            end
            pend <= pend ? ~done : load;
            if (HREADYOUTS | pend) begin
                dphase <= done;
            end
        end
    end

    // A held SEQ restarts as NONSEQ: the arbitration gap broke the burst.
    assign sel_ip      = pend | HSELS;
    assign addr_ip     = pend ? addr_q     : HADDRS;
    assign trans_ip    = pend ? HTRANS_NONSEQ : HTRANSS;
    assign write_ip    = pend ? write_q    : HWRITES;
    assign size_ip     = pend ? size_q     : HSIZES;
    assign burst_ip    = pend ? burst_q    : HBURSTS;
    assign prot_ip     = pend ? prot_q     : HPROTS;
    assign master_ip   = pend ? master_q   : HMASTERS;
    assign mastlock_ip = pend ? mastlock_q : HMASTLOCKS;

    assign HREADYOUTS = dphase ? readyout_ip : ~pend;
    assign HRESPS     = dphase ? resp_ip : HRESP_OKAY;

endmodule
